rom_read_arbiter: RTL
=====================

// Module: rom_read_arbiter
// PURPOSE
//  Shares one single_port_rom (synchronous read, 6-bit address, 8-bit data) among NREQ requesters.
//  Round-robin arbitration with a valid/ready request handshake. Fully pipelined: one ROM read per clock.
//  Returns data in request order, tagged by a one-hot rsp_valid.
//  Sits between client blocks (sequencers, table lookups) and the ROM instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  AW       6   ROM address width
//  DW       8   ROM data width
//  ROM_LAT  1   clock edges from a change on rom_a to valid data on rom_d
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  req_valid  in   NREQ     requester i has a read pending
//  req_addr   in   NREQ*AW  address of requester i, in slice [i*AW +: AW]
//  req_ready  out  NREQ     one-hot grant, combinational; accept = req_valid[i] & req_ready[i]
//  rsp_valid  out  NREQ     one-hot, single-cycle pulse; rsp_data is valid for requester i
//  rsp_data   out  DW       read data, registered
//  busy       out  1        at least one read is in flight
//  rom_a      out  AW       registered address to the ROM
//  rom_d      in   DW       ROM read data
//  grant_cnt  out  NREQ*16  per-requester grant counters (only with ROM_ARB_STATS_EN)
// BEHAVIOUR
//  Reset values: rom_a=0, rsp_valid=0, rsp_data=0, busy=0, rr pointer=0, tag pipe cleared, grant_cnt=0.
//  Arbitration:
//   - Starting at the rr pointer, the first i with req_valid[i] receives req_ready[i]=1.
//   - All other req_ready bits are 0. req_ready is 0 everywhere when no request is pending.
//   - On an accept at edge E: rom_a <= req_addr[i]; rr pointer <= (i+1) mod NREQ (wraps NREQ-1 -> 0).
//   - The same requester may be granted on consecutive cycles only when no other requester is valid.
//  Requester rule: hold req_valid and req_addr stable until accepted. The arbiter never retracts a grant
//   within a cycle.
//  Tag pipeline: a one-hot tag plus valid bit, depth ROM_LAT+1, advances every clock.
//   - No stalls, because responses have no backpressure.
//  Latency: accept at edge E -> rsp_data <= rom_d at edge E+ROM_LAT+1 -> rsp_valid[i]=1 for exactly one
//   cycle after that edge. With ROM_LAT=1 the response is 2 cycles after accept.
//  Between responses: rsp_data holds its last value and rsp_valid=0.
//  Ordering: responses return strictly in accept order. Back-to-back accepts give back-to-back responses.
//  busy = OR of the tag-pipe valid bits.
//  Idle cycles: rom_a holds its last value. ROM reads in idle cycles are ignored because no tag is valid.
//  Address arithmetic: none. The full AW bits pass through, so 0..2^AW-1 are all legal and addr 63 needs
//   no special case.
//  Reset mid-operation: everything clears immediately and in-flight reads are dropped.
//   - No rsp_valid pulse may appear after rst_n rises for reads accepted before reset.
// CONFIGURATION
//  `ROM_ARB_STATS_EN defined:
//   - Per-requester 16-bit saturating grant counter, +1 on each accept.
//   - Holds at 16'hFFFF once reached. Cleared only by reset.
//   - Exported on grant_cnt[i*16 +: 16].
//  Not defined: grant_cnt port and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package rom_arb_pkg: NREQ/AW/DW/ROM_LAT defaults, CNT_W=16, CNT_MAX, one-hot/index helper function.
//  Sub-module rr_arbiter: combinational masked round-robin pick.
//   - Inputs: req and ptr. Outputs: one-hot gnt and index.
//  Top level holds the registers: rr pointer, rom_a, tag pipe, rsp regs, and optional counters.
// TESTING (bench ROM model preloaded with mem[a] = a ^ 8'hA5; compare every rsp against the model)
//  1 Only req0 valid, addr 6'h05:
//    -> req_ready=4'b0001 in the same cycle; rom_a=5 after the edge;
//    -> rsp_valid=4'b0001 two cycles after accept, rsp_data=8'hA0.
//  2 All 4 valid continuously, addrs 10,11,12,13:
//    -> grants 0,1,2,3,0,... one per cycle;
//    -> responses back-to-back in the same order with the correct data; busy stays 1.
//  3 Wrap: after a grant to req3, req0 and req3 both valid -> req0 is granted (pointer wrapped to 0).
//  4 req2 sweeps addresses 0..63 with no gaps:
//    -> 64 consecutive rsp_valid[2] pulses;
//    -> addr 63 returns 8'h9A and addr 0 returns 8'hA5; busy falls 2 cycles after the last accept.
//  5 Drop rst_n with 2 reads in flight:
//    -> all outputs go to reset values at once;
//    -> no rsp_valid in the 5 cycles after release; next grant goes to req0.
//  6 With ROM_ARB_STATS_EN:
//    -> 300 accepts to req1 -> grant_cnt[31:16]=300;
//    -> 70000 accepts to req0 -> grant_cnt[15:0]=16'hFFFF.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Package: rom_arb_pkg
// Shared defaults and helpers for rom_read_arbiter and its round-robin picker.
//   NREQ_DEF/AW_DEF/DW_DEF/ROM_LAT_DEF : default parameter values
//   CNT_W / CNT_MAX                    : width and saturation value of the grant counters
//   onehot_to_idx()                    : index of the set bit in a one-hot vector (up to 8 bits)
package rom_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 6;
  localparam int DW_DEF      = 8;
  localparam int ROM_LAT_DEF = 1;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Returns the position of the set bit; 0 when the vector is all zero.
  function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Module: rr_arbiter
// Combinational round-robin pick: scans the requests starting at ptr and
// grants the first one found, wrapping NREQ-1 -> 0.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  PW    index with highest priority this cycle
//   gnt  out NREQ  one-hot grant, all zero when nothing is requested
//   idx  out PW    index of the granted request (0 when gnt is zero)
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    sum   = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // Position ptr+k modulo NREQ, done with one conditional subtract so
      // non-power-of-two NREQ wraps correctly.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      pos = sum[PW-1:0];
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign idx = PW'(onehot_to_idx(8'(gnt)));

endmodule

// File: rtl/rom_read_arbiter.sv
// Module: rom_read_arbiter
// Shares one synchronous-read ROM among NREQ requesters. Round-robin grant,
// one ROM read per clock, responses returned in accept order with a one-hot
// rsp_valid pulse naming the requester.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   req_valid   requester i has a read pending
//   req_addr    address of requester i in slice [i*AW +: AW]
//   req_ready   one-hot combinational grant
//   rsp_valid   one-hot single-cycle response pulse
//   rsp_data    registered read data, holds between responses
//   busy        at least one read in flight
//   rom_a       registered ROM address
//   rom_d       ROM read data
//   grant_cnt   per-requester 16-bit saturating accept counters
//               (present only when ROM_ARB_STATS_EN is defined)
//
// Handshake: a request is accepted on a rising edge where req_valid[i] and
// req_ready[i] are both 1. A requester keeps req_valid/req_addr stable until
// accepted; req_ready depends only on req_valid and the rr pointer, so a grant
// is never withdrawn within a cycle. Responses have no backpressure.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               busy,
  output logic [AW-1:0]      rom_a,
  input  logic [DW-1:0]      rom_d
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            accept;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   rom_a_q, rom_a_d;
  logic [AW-1:0]   addr_sel;

  // Stage s holds the tag of the read issued s+1 edges ago; the last stage
  // lines up with valid ROM data on rom_d.
  logic [ROM_LAT:0]           tag_vld_q, tag_vld_d;
  logic [ROM_LAT:0][NREQ-1:0] tag_oh_q, tag_oh_d;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  // gnt is only ever set on a valid requester, so any grant is an accept.
  assign accept    = |gnt;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) addr_sel = req_addr[i*AW +: AW];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    rom_a_d = rom_a_q;
    if (accept) begin
      rom_a_d = addr_sel;
      ptr_d   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_oh_d     = '0;
    tag_vld_d[0] = accept;
    tag_oh_d[0]  = gnt;
    for (int s = 1; s <= ROM_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_oh_d[s]  = tag_oh_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[ROM_LAT]) begin
      rsp_valid_d = tag_oh_q[ROM_LAT];
      rsp_data_d  = rom_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rom_a_q     <= '0;
      tag_vld_q   <= '0;
      tag_oh_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rom_a_q     <= rom_a_d;
      tag_vld_q   <= tag_vld_d;
      tag_oh_q    <= tag_oh_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rom_a     = rom_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |tag_vld_q;

`ifdef ROM_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
